// File: rtl/blck_builder_stream.sv
// Streaming block builder: packs byte-qualified bus words into BLCK_SIZE-bit blocks and
// appends the domain-separation constant plus zero padding at message end.
module blck_builder_stream #(
    parameter int unsigned BUS_SIZE  = 32,
    parameter int unsigned BLCK_SIZE = 256,
    parameter logic [7:0]  PAD_CNST  = 8'h01
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [BUS_SIZE-1:0]    data_in,
    input  logic [BUS_SIZE/8-1:0]  data_in_validity,
    input  logic                   data_in_last,
    input  logic                   data_in_valid,
    output logic                   data_in_ready,
    input  logic                   abort,
    output logic [BLCK_SIZE-1:0]   blck_out,
    output logic [BLCK_SIZE/8-1:0] blck_out_validity,
    output logic                   blck_out_last,
    output logic                   blck_out_padded,
    output logic                   blck_out_valid,
    input  logic                   blck_out_ready
);
    localparam int unsigned WORDS = BLCK_SIZE / BUS_SIZE;
    localparam int unsigned BYTES = BUS_SIZE / 8;
    localparam int unsigned CNT_W = $clog2(WORDS + 1);
    localparam int unsigned POP_W = $clog2(BYTES + 1);

    typedef enum logic [1:0] {StFill, StPad, StOut} state_t;

    state_t                 r_state, w_state_nxt;
    logic [CNT_W-1:0]       r_cnt, w_cnt_inc;
    logic                   r_cst_done, r_last, r_padded;
    logic [BLCK_SIZE-1:0]   r_buf;
    logic [BLCK_SIZE/8-1:0] r_vld;
    logic [POP_W-1:0]       w_pop;
    logic [BUS_SIZE-1:0]    w_fmt, w_word;
    logic [BYTES-1:0]       w_wvld;
    logic                   w_fmt_cst, w_wr, w_clear, w_set_cst, w_set_last;

    // Validity is a contiguous prefix, so its popcount is the first unused byte index.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < BYTES; i++) begin
            w_pop = w_pop + POP_W'(data_in_validity[i]);
        end
        w_fmt = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (data_in_validity[i]) begin
                w_fmt[8*i +: 8] = data_in[8*i +: 8];
            end else if (data_in_last && (w_pop == POP_W'(i))) begin
                w_fmt[8*i +: 8] = PAD_CNST;
            end
        end
        w_fmt_cst = data_in_last && (w_pop != POP_W'(BYTES));
    end

    assign w_cnt_inc = r_cnt + 1'b1;

    always_comb begin
        w_state_nxt    = r_state;
        w_wr           = 1'b0;
        w_word         = '0;
        w_wvld         = '0;
        w_set_cst      = 1'b0;
        w_set_last     = 1'b0;
        w_clear        = 1'b0;
        data_in_ready  = 1'b0;
        blck_out_valid = 1'b0;
        unique case (r_state)
            StFill: begin
                data_in_ready = 1'b1;
                if (abort) begin
                    w_clear = 1'b1;
                end else if (data_in_valid) begin
                    w_wr       = 1'b1;
                    w_word     = w_fmt;
                    w_wvld     = data_in_validity;
                    w_set_last = data_in_last;
                    w_set_cst  = w_fmt_cst;
                    if (w_cnt_inc == CNT_W'(WORDS)) begin
                        w_state_nxt = StOut;
                    end else if (data_in_last) begin
                        w_state_nxt = StPad;
                    end
                end
            end
            StPad: begin
                if (abort) begin
                    w_clear     = 1'b1;
                    w_state_nxt = StFill;
                end else begin
                    w_wr      = 1'b1;
                    w_word    = r_cst_done ? '0 : BUS_SIZE'(PAD_CNST);
                    w_set_cst = 1'b1;
                    if (w_cnt_inc == CNT_W'(WORDS)) begin
                        w_state_nxt = StOut;
                    end
                end
            end
            StOut: begin
                blck_out_valid = 1'b1;
                if (blck_out_ready) begin
                    w_clear     = 1'b1;
                    w_state_nxt = StFill;
                end
            end
            default: w_state_nxt = StFill;
        endcase
    end

    // Buffer data survives the output handshake; only validity and flags are cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StFill;
            r_cnt      <= '0;
            r_cst_done <= 1'b0;
            r_last     <= 1'b0;
            r_padded   <= 1'b0;
            r_buf      <= '0;
            r_vld      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_clear) begin
                r_cnt      <= '0;
                r_cst_done <= 1'b0;
                r_last     <= 1'b0;
                r_padded   <= 1'b0;
                r_vld      <= '0;
            end else if (w_wr) begin
                r_cnt <= w_cnt_inc;
                if (w_set_cst) begin
                    r_cst_done <= 1'b1;
                    r_padded   <= 1'b1;
                end
                if (w_set_last) begin
                    r_last <= 1'b1;
                end
                for (int k = 0; k < WORDS; k++) begin
                    if (r_cnt == CNT_W'(k)) begin
                        r_buf[BUS_SIZE*k +: BUS_SIZE] <= w_word;
                        r_vld[BYTES*k +: BYTES]       <= w_wvld;
                    end
                end
            end
        end
    end

    assign blck_out          = r_buf;
    assign blck_out_validity = r_vld;
    assign blck_out_last     = r_last;
    assign blck_out_padded   = r_padded;

endmodule

// File: doc/blck_builder_stream.md
# blck_builder_stream

Streaming block builder with integrated control. It accepts a byte-qualified input word stream over a valid/ready handshake and assembles BLCK_SIZE-bit blocks. On message end it applies domain-separation constant insertion and zero padding, then presents each completed block over a second valid/ready handshake. It sits between the bus-level input FIFO and the permutation/absorb datapath, and replaces the separate builder datapath plus external controller pair with one parametrised, self-sequenced block.

## Interface
- BUS_SIZE, 32, input word width in bits; legal values 8, 16, 32, 64.
- BLCK_SIZE, 256, output block width in bits; must be a multiple of BUS_SIZE. WORDS = BLCK_SIZE/BUS_SIZE.
- PAD_CNST, 8'h01, domain-separation constant byte inserted at the first unused byte position.

- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- data_in  in  BUS_SIZE  input word; byte i = bits [8i+7:8i].
- data_in_validity  in  BUS_SIZE/8  byte validity; must be a contiguous prefix from bit 0 (e.g. 4'b0111). Other patterns are undefined.
- data_in_last  in  1  word is the final word of the message.
- data_in_valid  in  1  input handshake valid.
- data_in_ready  out  1  input handshake ready.
- abort  in  1  synchronous discard of the partial block.
- blck_out  out  BLCK_SIZE  assembled block; word k of the block = bits [BUS_SIZE*(k+1)-1 : BUS_SIZE*k].
- blck_out_validity  out  BLCK_SIZE/8  per-byte validity of data bytes only. Constant and padding bytes are 0.
- blck_out_last  out  1  block contains the message's last word.
- blck_out_padded  out  1  block contains the constant and/or padding.
- blck_out_valid  out  1  output handshake valid.
- blck_out_ready  in  1  output handshake ready.

## Operation
- FSM states: FILL, PAD, OUT. Word counter cnt, width clog2(WORDS+1). Flag cst_done.
- **FILL**
  - data_in_ready = 1. On accept (valid & ready), formatted word → slot cnt, validity → slot cnt, cnt++.
  - Formatting: invalid bytes forced to 0. If data_in_last and the word is partial, byte at index popcount(validity) = PAD_CNST, and cst_done is set.
  - Next state:
    - If cnt reaches WORDS → OUT.
    - Else if data_in_last → PAD.
    - Else stay in FILL.
- **PAD**
  - data_in_ready = 0. One slot per cycle: word = {0…, PAD_CNST} if !cst_done (then set cst_done), else all-zero. Validity 0, cnt++.
  - cnt == WORDS → OUT.
- **OUT**
  - blck_out_valid = 1, data_in_ready = 0.
  - On blck_out_ready: cnt, cst_done, the validity register and the last/padded flags clear, buffer is kept, → FILL.
- Constant is not carried across blocks. A message whose last word exactly fills a block gets no constant: padded = 0, last = 1.
- Empty last word (validity all 0, data_in_last = 1): accepted as a slot with PAD_CNST at byte 0.
- abort in FILL or PAD: cnt, cst_done and flags clear, state → FILL next cycle. abort is ignored in OUT. abort has priority over a simultaneous accept; that word is dropped.
- Buffer contents of unwritten slots are don't-care. Every slot is written before OUT.

## Timing
- Reset (async, immediate): state FILL, cnt 0, cst_done 0.
  - Outputs: blck_out 0, blck_out_validity 0, blck_out_last 0, blck_out_padded 0, blck_out_valid 0, data_in_ready 1 (combinational from state).
  - Stimulus must not drive data_in_valid while rst is high.
- Latency: blck_out_valid rises 1 cycle after the accept that fills slot WORDS-1. With padding, it rises 1 + (WORDS − filled slots) cycles after the last accept.
- Throughput: a full block takes WORDS accept cycles + ≥1 OUT cycle. There is a 1-cycle input bubble per block.
- Output hold: blck_out, validity, last and padded stay stable while blck_out_valid = 1 and blck_out_ready = 0.
- Reset mid-PAD or mid-OUT drops the block without emitting it.

## Test plan
BUS_SIZE=32, BLCK_SIZE=128, PAD_CNST=8'h01.

- **Exact fill:** words 0x03020100, 0x07060504, 0x0b0a0908, 0x0f0e0d0c (all validity 4'hF, last on 4th), out_ready=1 → one cycle after the 4th accept: blck_out = 0x0f0e0d0c_0b0a0908_07060504_03020100, validity 16'hFFFF, last 1, padded 0.
- **Partial last:** 0x03020100 (4'hF), then 0xAABB0706 (4'b0011, last) → PAD 2 cycles, then OUT: blck_out = 0x00000000_00000000_00010706_03020100, validity 16'h003F, last 1, padded 1.
- **Full last word, block not full:** single word 0x11223344 (4'hF, last) → slots 1..3 = 0x00000001, 0, 0; validity 16'h000F; blck_out_valid rises 4 cycles after accept.
- **Multi-block with backpressure:** 6 full words, last on the 6th, out_ready held low 5 cycles on block 1.
  - Block 1: held stable, data_in_ready = 0 throughout, last 0, padded 0.
  - After the handshake, data_in_ready = 1 next cycle.
  - Block 2: words 4, 5, 0x00000001, 0; last 1; padded 1.
- **Abort/reset:** 2 words accepted, abort pulse → next 4 full words form a clean block with last/padded as in the exact-fill case. Async rst asserted mid-PAD → all outputs 0 immediately, no block emitted.
